uart_prog_loader: RTL



---
 rtl/uart_prog_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver and 4-byte packet parser that emits program-memory write strobes.
// Latency: strobe/error registered one cycle after the byte completes; the line passes a 2-flop synchroniser first.
// Backpressure: none; the serial line cannot be stalled, so every byte is consumed as it arrives.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       UART_RXD,
    output logic [3:0] serial_addr,
    output logic [7:0] serial_value,
    output logic       serial_WE,
    output logic       pkt_err,
    output logic       busy
);
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_CSUM} p_state_t;

    rx_state_t        rx_state, rx_next;
    p_state_t         p_state, p_next;
    logic             rx_meta, rxs, rxs_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_dat;
    logic             byte_vld;
    logic [7:0]       byte_dat;
    logic [3:0]       addr_q;
    logic [7:0]       data_q;
    logic [TMO_W-1:0] idle_cnt;

    logic rx_fall, start_edge, bit_tick;
    logic sample_dat, stop_ok, frame_err;
    logic addr_bad, csum_match, write_ok, csum_bad, tmo_hit;

    assign rx_fall    = rxs_prev & ~rxs;
    assign start_edge = (rx_state == RX_IDLE) && rx_fall;
    assign bit_tick   = (clk_cnt == BIT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= UART_RXD;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // ---------------- receiver FSM ----------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            // A line already high again at mid start bit was a glitch.
            RX_START: if (clk_cnt == HALF_LAST) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        sample_dat = (rx_state == RX_DATA) && bit_tick;
        stop_ok    = (rx_state == RX_STOP) && bit_tick && rxs;
        frame_err  = (rx_state == RX_STOP) && bit_tick && !rxs;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
            byte_vld  <= 1'b0;
            byte_dat  <= '0;
        end else begin
            byte_vld <= stop_ok;
            if (stop_ok) byte_dat <= shift_dat;
            if (rx_state == RX_IDLE || rx_next != rx_state || bit_tick) clk_cnt <= '0;
            else                                                        clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == RX_IDLE) bit_cnt <= '0;
            if (sample_dat) begin
                shift_dat <= {rxs, shift_dat[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- packet parser FSM ----------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) p_state <= P_SYNC;
        else     p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (frame_err || tmo_hit) begin
            p_next = P_SYNC;
        end else if (byte_vld) begin
            case (p_state)
                P_SYNC:  if (byte_dat == SYNC_BYTE) p_next = P_ADDR;
                P_ADDR:  p_next = (byte_dat[7:4] == 4'h0) ? P_DATA : P_SYNC;
                P_DATA:  p_next = P_CSUM;
                P_CSUM:  p_next = P_SYNC;
                default: p_next = P_SYNC;
            endcase
        end
    end

    always_comb begin
        addr_bad   = byte_vld && (p_state == P_ADDR) && (byte_dat[7:4] != 4'h0);
        csum_match = (byte_dat == SYNC_BYTE + {4'h0, addr_q} + data_q);
        write_ok   = byte_vld && (p_state == P_CSUM) && csum_match;
        csum_bad   = byte_vld && (p_state == P_CSUM) && !csum_match;
        // Idle time only accrues between bytes of an open packet.
        tmo_hit    = (p_state != P_SYNC) && (rx_state == RX_IDLE) && !rx_fall
                     && (idle_cnt == TMO_LAST);
        busy       = (rx_state != RX_IDLE) || (p_state != P_SYNC);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            idle_cnt     <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            serial_addr  <= '0;
            serial_value <= '0;
            serial_WE    <= 1'b0;
            pkt_err      <= 1'b0;
        end else begin
            if (start_edge || p_state == P_SYNC || tmo_hit) idle_cnt <= '0;
            else if (rx_state == RX_IDLE)                   idle_cnt <= idle_cnt + TMO_W'(1);
            if (byte_vld && p_state == P_ADDR) addr_q <= byte_dat[3:0];
            if (byte_vld && p_state == P_DATA) data_q <= byte_dat;
            serial_WE <= write_ok;
            pkt_err   <= frame_err || addr_bad || csum_bad || tmo_hit;
            if (write_ok) begin
                serial_addr  <= addr_q;
                serial_value <= data_q;
            end
        end
    end
endmodule
